// File: rtl/bisr_ru_alloc_scheduler_pkg.sv
// Shared types and width helpers for the BISR recompute-unit allocation slice.
// Contents: the scheduler state enum and constant functions that derive the
// RW / CW / PE_IDX_W / FC_W widths from the array geometry.
package bisr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT,
    ST_SCAN,
    ST_DONE
  } state_t;

  // Row-field width RW = $clog2(ROWS)
  function automatic int unsigned rw_of(input int unsigned rows);
    return $clog2(rows);
  endfunction

  // Column-field width CW = $clog2(COLS)
  function automatic int unsigned cw_of(input int unsigned cols);
    return $clog2(cols);
  endfunction

  // PE index width PE_IDX_W = $clog2(ROWS*COLS)
  function automatic int unsigned pe_idx_w_of(input int unsigned rows, input int unsigned cols);
    return $clog2(rows * cols);
  endfunction

  // Fault counter width FC_W = $clog2(ROWS*COLS+1)
  function automatic int unsigned fc_w_of(input int unsigned rows, input int unsigned cols);
    return $clog2(rows * cols + 1);
  endfunction

endpackage

// File: rtl/bisr_ru_alloc_scheduler_table.sv
// ru_alloc_table: append-only table of NUM_RU recompute-unit slots.
// Ports:
//   clk, rst            clock, synchronous active-low reset
//   clear               empties the table (pointer back to slot 0)
//   append_valid        write append_row/append_col into the next free slot
//   append_row/col      PE coordinates to record
//   ru_en               bit k set once slot k has been written
//   ru_row_mapping      slot k row at [k*RW +: RW]
//   ru_col_mapping      slot k column at [k*CW +: CW]
//   full                every slot is in use; further appends are dropped
module ru_alloc_table #(
  parameter int unsigned NUM_RU = 4,
  parameter int unsigned RW     = 2,
  parameter int unsigned CW     = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 append_valid,
  input  logic [RW-1:0]        append_row,
  input  logic [CW-1:0]        append_col,
  output logic [NUM_RU-1:0]    ru_en,
  output logic [RW*NUM_RU-1:0] ru_row_mapping,
  output logic [CW*NUM_RU-1:0] ru_col_mapping,
  output logic                 full
);

  localparam int unsigned PW = $clog2(NUM_RU + 1);

  logic [PW-1:0] ptr;

  assign full = (ptr == PW'(NUM_RU));

  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr            <= '0;
      ru_en          <= '0;
      ru_row_mapping <= '0;
      ru_col_mapping <= '0;
    end else if (clear) begin
      ptr            <= '0;
      ru_en          <= '0;
      ru_row_mapping <= '0;
      ru_col_mapping <= '0;
    end else if (append_valid && !full) begin
      ru_en[ptr]                    <= 1'b1;
      ru_row_mapping[ptr*RW +: RW]  <= append_row;
      ru_col_mapping[ptr*CW +: CW]  <= append_col;
      ptr                           <= ptr + 1'b1;
    end
  end

endmodule

// File: rtl/bisr_ru_alloc_scheduler.sv
// bisr_ru_alloc_scheduler: launches the STW self-test, captures the PE fault
// map, then scans it row-major and assigns faulty PEs to recompute units.
// Ports:
//   clk, rst         clock, synchronous active-low reset
//   start            run request, honoured only in IDLE
//   stw_start        one-cycle launch pulse to the array self-test
//   stw_complete     self-test finished (sampled only while waiting)
//   stw_result_mat   fault map, bit r*COLS+c = PE(r,c) faulty
//   ru_en            RU k allocated
//   ru_row_mapping   row served by RU k at [k*RW +: RW]
//   ru_col_mapping   column served by RU k at [k*CW +: CW]
//   fault_count      faulty PEs found in the last scan
//   busy             high outside IDLE
//   done             one-cycle end-of-sequence pulse
//   overflow         more faults than RUs (sticky until next start)
//   timeout          self-test never completed (sticky until next start)
module bisr_ru_alloc_scheduler
  import bisr_pkg::*;
#(
  parameter int unsigned ROWS         = 4,
  parameter int unsigned COLS         = 4,
  parameter int unsigned NUM_RU       = 4,
  parameter int unsigned TEST_TIMEOUT = 255
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  output logic                                  stw_start,
  input  logic                                  stw_complete,
  input  logic [ROWS*COLS-1:0]                  stw_result_mat,
  output logic [NUM_RU-1:0]                     ru_en,
  output logic [$clog2(ROWS)*NUM_RU-1:0]        ru_row_mapping,
  output logic [$clog2(COLS)*NUM_RU-1:0]        ru_col_mapping,
  output logic [$clog2(ROWS*COLS+1)-1:0]        fault_count,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  overflow,
  output logic                                  timeout
);

  localparam int unsigned RW       = rw_of(ROWS);
  localparam int unsigned CW       = cw_of(COLS);
  localparam int unsigned PE_IDX_W = pe_idx_w_of(ROWS, COLS);
  localparam int unsigned FC_W     = fc_w_of(ROWS, COLS);
  localparam int unsigned WCW      = $clog2(TEST_TIMEOUT + 1);

  state_t                state, next_state;
  logic [WCW-1:0]        wait_cnt;
  logic [PE_IDX_W-1:0]   scan_idx;
  logic [ROWS*COLS-1:0]  fault_map;

  logic                  table_clear;
  logic                  append_valid;
  logic                  table_full;
  logic [RW-1:0]         cur_row;
  logic [CW-1:0]         cur_col;

  logic                  wait_expired;
  logic                  scan_last;

  assign wait_expired = (wait_cnt == WCW'(TEST_TIMEOUT - 1));
  assign scan_last    = (scan_idx == PE_IDX_W'(ROWS * COLS - 1));

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state <= ST_IDLE;
    else      state <= next_state;
  end

  // Next-state logic; completion takes priority over the timeout
  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE:   if (start) next_state = ST_LAUNCH;
      ST_LAUNCH: next_state = ST_WAIT;
      ST_WAIT: begin
        if (stw_complete)      next_state = ST_SCAN;
        else if (wait_expired) next_state = ST_DONE;
      end
      ST_SCAN:   if (scan_last) next_state = ST_DONE;
      ST_DONE:   next_state = ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  // Outputs and table controls
  always_comb begin
    int unsigned idx;
    idx          = 32'(scan_idx);
    stw_start    = (state == ST_LAUNCH);
    busy         = (state != ST_IDLE);
    done         = (state == ST_DONE);
    table_clear  = (state == ST_IDLE) && start;
    append_valid = (state == ST_SCAN) && fault_map[scan_idx];
    cur_row      = RW'(idx / COLS);
    cur_col      = CW'(idx % COLS);
  end

  // Datapath: wait counter, captured map, scan index, status flags
  always_ff @(posedge clk) begin
    if (!rst) begin
      wait_cnt    <= '0;
      scan_idx    <= '0;
      fault_map   <= '0;
      fault_count <= '0;
      overflow    <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            wait_cnt    <= '0;
            scan_idx    <= '0;
            fault_count <= '0;
            overflow    <= 1'b0;
            timeout     <= 1'b0;
          end
        end
        ST_WAIT: begin
          wait_cnt <= wait_cnt + 1'b1;
          if (stw_complete)      fault_map <= stw_result_mat;
          else if (wait_expired) timeout   <= 1'b1;
        end
        ST_SCAN: begin
          scan_idx <= scan_idx + 1'b1;
          if (fault_map[scan_idx]) begin
            fault_count <= fault_count + FC_W'(1);
            if (table_full) overflow <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  ru_alloc_table #(
    .NUM_RU (NUM_RU),
    .RW     (RW),
    .CW     (CW)
  ) u_table (
    .clk            (clk),
    .rst            (rst),
    .clear          (table_clear),
    .append_valid   (append_valid),
    .append_row     (cur_row),
    .append_col     (cur_col),
    .ru_en          (ru_en),
    .ru_row_mapping (ru_row_mapping),
    .ru_col_mapping (ru_col_mapping),
    .full           (table_full)
  );

endmodule
